// File: rtl/seq_pkg.sv
// Shared definitions for the sequence game core: FSM state encoding,
// tile index width and default playback timing.
// Ports: none (package).
package seq_pkg;

    // Tile index width, matching the LFSR output.
    localparam int NUM_W = 4;

    // Default game length and playback timing (50 MHz core clock).
    localparam int DEF_MAX_LEN    = 32;
    localparam int DEF_ON_CYCLES  = 25_000_000;
    localparam int DEF_OFF_CYCLES = 12_500_000;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_APPEND   = 3'd1;
    localparam logic [2:0] ST_SHOW_OFF = 3'd2;
    localparam logic [2:0] ST_SHOW_ON  = 3'd3;
    localparam logic [2:0] ST_INPUT    = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        APPEND   = ST_APPEND,
        SHOW_OFF = ST_SHOW_OFF,
        SHOW_ON  = ST_SHOW_ON,
        INPUT    = ST_INPUT
    } state_t;

endpackage

// File: rtl/sequence_ram.sv
// Storage for the generated tile sequence, DEPTH entries of WIDTH bits.
// Ports: clock; we_i/waddr_i/wdata_i synchronous write; raddr_i -> rdata_o
//        combinational read (out-of-range address reads as 0). No reset.
module sequence_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The engine parks idx at len after the last playback tile, which can
    // equal DEPTH; that read is never used, but keep it well defined.
    assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/sequence_engine.sv
// Memory-game core: grows a random tile sequence one tile per round, replays
// it as timed on/off pulses, then checks the player's presses in order.
// Ports: clock, reset (async active-low), start; rnd_num/rnd_get to LFSR;
//        press_valid/press_tile from keypad; show_valid/show_tile to display;
//        await_input, round_ok, fail, win, level to score logic.
module sequence_engine
    import seq_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int NUM_W      = seq_pkg::NUM_W,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_W-1:0]             rnd_num,
    output logic                         rnd_get,
    input  logic                         press_valid,
    input  logic [NUM_W-1:0]             press_tile,
    output logic                         show_valid,
    output logic [NUM_W-1:0]             show_tile,
    output logic                         await_input,
    output logic                         round_ok,
    output logic                         fail,
    output logic                         win,
    output logic [$clog2(MAX_LEN+1)-1:0] level
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int AW      = $clog2(MAX_LEN);
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic               rnd_get_q, show_valid_q, await_q;
    logic               round_ok_q, round_ok_d;
    logic               fail_q, fail_d;
    logic               win_q, win_d;

    logic               mem_we;
    logic [NUM_W-1:0]   mem_tile;

    sequence_ram #(
        .DEPTH (MAX_LEN),
        .WIDTH (NUM_W),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .we_i    (mem_we),
        .waddr_i (len_q[AW-1:0]),
        .wdata_i (rnd_num),
        .raddr_i (idx_q[AW-1:0]),
        .rdata_o (mem_tile)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        mem_we     = 1'b0;
        round_ok_d = 1'b0;
        fail_d     = 1'b0;
        win_d      = 1'b0;

        if (start) begin
            // New game overrides whatever is in flight, including a press.
            state_d = APPEND;
            len_d   = '0;
            idx_d   = '0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                APPEND: begin
                    mem_we  = 1'b1;
                    len_d   = len_q + LEN_W'(1);
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = SHOW_OFF;
                end
                SHOW_OFF: begin
                    if (timer_q == OFF_LAST) begin
                        timer_d = '0;
                        // idx reaches len only after the final tile's gap.
                        if (idx_q == len_q) begin
                            idx_d   = '0;
                            state_d = INPUT;
                        end else begin
                            state_d = SHOW_ON;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                SHOW_ON: begin
                    if (timer_q == ON_LAST) begin
                        timer_d = '0;
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = SHOW_OFF;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                INPUT: begin
                    if (press_valid) begin
                        if (press_tile != mem_tile) begin
                            fail_d  = 1'b1;
                            state_d = IDLE;
                        end else if (idx_q != len_q - LEN_W'(1)) begin
                            idx_d = idx_q + LEN_W'(1);
                        end else begin
                            round_ok_d = 1'b1;
                            if (len_q == LEN_MAX) begin
                                win_d   = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = APPEND;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State-indicating outputs are registered from the next state so they
    // line up exactly with the cycles spent in that state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            rnd_get_q    <= 1'b0;
            show_valid_q <= 1'b0;
            await_q      <= 1'b0;
            round_ok_q   <= 1'b0;
            fail_q       <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            rnd_get_q    <= (state_d == APPEND);
            show_valid_q <= (state_d == SHOW_ON);
            await_q      <= (state_d == INPUT);
            round_ok_q   <= round_ok_d;
            fail_q       <= fail_d;
            win_q        <= win_d;
        end
    end

    assign rnd_get     = rnd_get_q;
    assign show_valid  = show_valid_q;
    assign show_tile   = show_valid_q ? mem_tile : '0;
    assign await_input = await_q;
    assign round_ok    = round_ok_q;
    assign fail        = fail_q;
    assign win         = win_q;
    assign level       = len_q;

endmodule

// File: tb/tb_sequence_engine.sv
module tb_sequence_engine;

    localparam int MAX_LEN = 3;
    localparam int ON      = 3;
    localparam int OFF     = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] rnd_num;
    logic       rnd_get;
    logic       press_valid;
    logic [3:0] press_tile;
    logic       show_valid;
    logic [3:0] show_tile;
    logic       await_input;
    logic       round_ok;
    logic       fail;
    logic       win;
    logic [1:0] level;

    sequence_engine #(
        .MAX_LEN    (MAX_LEN),
        .NUM_W      (4),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rnd_num     (rnd_num),
        .rnd_get     (rnd_get),
        .press_valid (press_valid),
        .press_tile  (press_tile),
        .show_valid  (show_valid),
        .show_tile   (show_tile),
        .await_input (await_input),
        .round_ok    (round_ok),
        .fail        (fail),
        .win         (win),
        .level       (level)
    );

    always #5 clock = ~clock;

    // {rnd_get, show_valid, show_tile[3:0], await_input, round_ok, fail, win, level[1:0]}
    typedef logic [11:0] vec_t;
    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(bit rg, bit sv, logic [3:0] st, bit aw,
                                bit ok, bit fl, bit wn, logic [1:0] lv);
        return {rg, sv, st, aw, ok, fl, wn, lv};
    endfunction

    function automatic vec_t obs();
        return {rnd_get, show_valid, show_tile, await_input, round_ok, fail, win, level};
    endfunction

    task automatic check(input string tag, input vec_t exp);
        vec_t o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

    task automatic push(input string tag, input vec_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Expected per-cycle trace of one round: APPEND, leading gap, then each
    // tile lit for ON clocks followed by an OFF gap, then the first INPUT cycle.
    // seq holds tile i in bits [4*i +: 4].
    task automatic push_round(input string tag, input logic [11:0] seq,
                              input int L, input bit ok);
        push({tag, "_append"}, mk(1, 0, 4'h0, 0, ok, 0, 0, 2'(L - 1)));
        for (int k = 0; k < OFF; k++) push({tag, "_gap0"}, mk(0, 0, 4'h0, 0, 0, 0, 0, 2'(L)));
        for (int i = 0; i < L; i++) begin
            for (int k = 0; k < ON; k++)  push({tag, "_on"},  mk(0, 1, seq[4*i +: 4], 0, 0, 0, 0, 2'(L)));
            for (int k = 0; k < OFF; k++) push({tag, "_off"}, mk(0, 0, 4'h0, 0, 0, 0, 0, 2'(L)));
        end
        push({tag, "_input"}, mk(0, 0, 4'h0, 1, 0, 0, 0, 2'(L)));
    endtask

    task automatic push_idle(input string tag, input int n, input logic [1:0] lv);
        for (int k = 0; k < n; k++) push(tag, mk(0, 0, 4'h0, 0, 0, 0, 0, lv));
    endtask

    // One clock per queued expectation; pulses last exactly one cycle.
    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clock);
            #1;
            start       = 1'b0;
            press_valid = 1'b0;
            e = sb.pop_front();
            check(e.tag, e.v);
        end
    endtask

    task automatic press(input logic [3:0] t);
        press_valid = 1'b1;
        press_tile  = t;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        rnd_num     = 4'h0;
        press_valid = 1'b0;
        press_tile  = 4'h0;

        // Reset state
        #3;
        check("reset_state", mk(0, 0, 4'h0, 0, 0, 0, 0, 2'd0));
        #10 reset = 1'b1;
        push_idle("post_reset_idle", 3, 2'd0);
        drain();

        // 1. Reset asserted mid-SHOW_ON aborts immediately
        start = 1'b1; rnd_num = 4'hA;
        push("t1_append", mk(1, 0, 4'h0, 0, 0, 0, 0, 2'd0));
        for (int k = 0; k < OFF; k++) push("t1_gap", mk(0, 0, 4'h0, 0, 0, 0, 0, 2'd1));
        push("t1_on", mk(0, 1, 4'hA, 0, 0, 0, 0, 2'd1));
        drain();
        reset = 1'b0;
        #1;
        check("t1_async_reset", mk(0, 0, 4'h0, 0, 0, 0, 0, 2'd0));
        #2 reset = 1'b1;
        push_idle("t1_idle_after_release", 3, 2'd0);
        drain();

        // 2. First round: sample A, play it back, reach INPUT
        start = 1'b1; rnd_num = 4'hA;
        push_round("t2", 12'h00A, 1, 1'b0);
        drain();

        // 3. Correct press -> round_ok, sample 5, play back {A,5}
        press(4'hA); rnd_num = 4'h5;
        push_round("t3", 12'h05A, 2, 1'b1);
        drain();

        // 4. Press A then wrong 7 -> fail, IDLE, level held, presses ignored
        press(4'hA);
        push("t4_press1", mk(0, 0, 4'h0, 1, 0, 0, 0, 2'd2));
        drain();
        press(4'h7);
        push("t4_fail", mk(0, 0, 4'h0, 0, 0, 1, 0, 2'd2));
        push_idle("t4_idle", 2, 2'd2);
        drain();
        press(4'hA);
        push_idle("t4_press_ignored", 3, 2'd2);
        drain();

        // 5. Three correct rounds -> round_ok and win together, no 4th sample
        start = 1'b1; rnd_num = 4'h3;
        push_round("t5_r1", 12'h003, 1, 1'b0);
        drain();
        press(4'h3); rnd_num = 4'h9;
        push_round("t5_r2", 12'h093, 2, 1'b1);
        drain();
        press(4'h3);
        push("t5_r2_p1", mk(0, 0, 4'h0, 1, 0, 0, 0, 2'd2));
        drain();
        press(4'h9); rnd_num = 4'hC;
        push_round("t5_r3", 12'hC93, 3, 1'b1);
        drain();
        press(4'h3);
        push("t5_r3_p1", mk(0, 0, 4'h0, 1, 0, 0, 0, 2'd3));
        drain();
        press(4'h9);
        push("t5_r3_p2", mk(0, 0, 4'h0, 1, 0, 0, 0, 2'd3));
        drain();
        press(4'hC); rnd_num = 4'h1;
        push("t5_win", mk(0, 0, 4'h0, 0, 1, 0, 1, 2'd3));
        push_idle("t5_idle_after_win", 3, 2'd3);
        drain();

        // 6. start during INPUT with a coincident (correct) press
        start = 1'b1; rnd_num = 4'h2;
        push_round("t6_r1", 12'h002, 1, 1'b0);
        drain();
        start = 1'b1; press(4'h2); rnd_num = 4'hE;
        push_round("t6_restart", 12'h00E, 1, 1'b0);
        drain();
        press(4'hE); rnd_num = 4'h1;
        push_round("t6_r2", 12'h01E, 2, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
